lut_frac_scan: RTL and testbench

Scan-configured, fracturable two-output LUT with optional registered outputs. It is the next-generation replacement for the parallel-loaded fracturable LUT used in CLB slices. Configuration shifts in serially through a daisy-chainable scan path, and a load counter flags a complete frame. Each output can be registered under configuration control, so the block serves as a complete LUT+FF pair inside the CLB.

---
 rtl/lut_frac_scan_if.sv | 33 +++
 rtl/lut_frac_scan.sv | 80 ++++++++
 tb/tb_lut_frac_scan.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/lut_frac_scan_if.sv
// Port bundle for lut_frac_scan: user address/enables, scan chain and LUT outputs.
// The slave modport is the LUT side; master is the driver side (CLB fabric or bench).
interface lut_frac_scan_if #(
    parameter int unsigned INPUTS = 4
);
    logic [2*INPUTS-1:0] addr;
    logic                ce;
    logic                cen;
    logic                config_in;
    logic                config_out;
    logic                cfg_done;
    logic [1:0]          out;

    modport master (
        output addr,
        output ce,
        output cen,
        output config_in,
        input  config_out,
        input  cfg_done,
        input  out
    );

    modport slave (
        input  addr,
        input  ce,
        input  cen,
        input  config_in,
        output config_out,
        output cfg_done,
        output out
    );
endinterface

// File: rtl/lut_frac_scan.sv
// Scan-configured fracturable two-output LUT with per-output optional registers.
// Config frame {use_fracture, reg1, reg0, first_lut, second_lut} shifts in MSB-first.
module lut_frac_scan #(
    parameter int unsigned INPUTS   = 4,
    parameter int unsigned MEM_SIZE = 2**INPUTS,
    parameter int unsigned CFG_BITS = 2*MEM_SIZE+3
) (
    input logic            clk,
    input logic            rst_n,
    lut_frac_scan_if.slave bus
);

    localparam int unsigned    CntW   = $clog2(CFG_BITS+1);
    localparam logic [CntW-1:0] CntMax = CntW'(CFG_BITS);

    logic [CFG_BITS-1:0] cfg_q, cfg_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                q1_q, q1_d;
    logic                q0_q, q0_d;

    logic                use_fracture, reg1, reg0;
    logic [MEM_SIZE-1:0] first_lut, second_lut;
    logic [INPUTS-1:0]   idx1, idx0;
    logic                c1, c0, sel, done;

    assign use_fracture = cfg_q[CFG_BITS-1];
    assign reg1         = cfg_q[CFG_BITS-2];
    assign reg0         = cfg_q[CFG_BITS-3];
    assign first_lut    = cfg_q[2*MEM_SIZE-1:MEM_SIZE];
    assign second_lut   = cfg_q[MEM_SIZE-1:0];
    assign done         = (cnt_q == CntMax);

    // addr[INPUTS-1] is not an input to either sub-LUT.
    logic unused_addr;
    assign unused_addr = bus.addr[INPUTS-1];

    // Cascade always takes the combinational c1, even when reg1 is set.
    always_comb begin
        idx1 = bus.addr[2*INPUTS-1:INPUTS];
        c1   = first_lut[idx1];
        sel  = use_fracture ? bus.addr[INPUTS] : c1;
        idx0 = {sel, bus.addr[INPUTS-2:0]};
        c0   = second_lut[idx0];
    end

    always_comb begin
        cfg_d = cfg_q;
        cnt_d = cnt_q;
        q1_d  = q1_q;
        q0_d  = q0_q;
        if (bus.cen) begin
            cfg_d = {cfg_q[CFG_BITS-2:0], bus.config_in};
            if (!done) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (bus.ce && done) begin
            q1_d = c1;
            q0_d = c0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cfg_q <= '0;
            cnt_q <= '0;
            q1_q  <= 1'b0;
            q0_q  <= 1'b0;
        end else begin
            cfg_q <= cfg_d;
            cnt_q <= cnt_d;
            q1_q  <= q1_d;
            q0_q  <= q0_d;
        end
    end

    assign bus.config_out = cfg_q[CFG_BITS-1];
    assign bus.cfg_done   = done;
    assign bus.out        = done ? {(reg1 ? q1_q : c1), (reg0 ? q0_q : c0)} : 2'b00;

endmodule

// File: tb/tb_lut_frac_scan.sv
// Randomized and directed bench for lut_frac_scan against a queue-based frame model.
module tb_lut_frac_scan;

    localparam int N    = 4;
    localparam int MEM  = 16;
    localparam int CFGN = 35;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    lut_frac_scan_if #(.INPUTS(N)) bus ();

    lut_frac_scan #(.INPUTS(N)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Model: m_q[0] is the oldest bit of the last CFGN shifted in (use_fracture).
    bit m_q[$];
    int m_cnt;
    bit m_r1, m_r0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        for (int i = 0; i < CFGN; i++) m_q.push_back(1'b0);
        m_cnt = 0;
        m_r1  = 1'b0;
        m_r0  = 1'b0;
    endtask

    // first_lut[i] sits 3+(MEM-1-i) bits after the frame start, second_lut[i] at 3+MEM+(MEM-1-i).
    task automatic model_comb(input logic [7:0] a, output bit c1, output bit c0);
        int i1, i0;
        bit sel;
        i1  = int'(a) / 16;
        c1  = m_q[3 + (MEM - 1 - i1)];
        sel = m_q[0] ? a[4] : c1;
        i0  = (sel ? 8 : 0) + (int'(a) % 8);
        c0  = m_q[3 + MEM + (MEM - 1 - i0)];
    endtask

    function automatic logic [1:0] model_out(input bit c1, input bit c0);
        if (m_cnt < CFGN) return 2'b00;
        return {(m_q[1] ? m_r1 : c1), (m_q[2] ? m_r0 : c0)};
    endfunction

    // Drive one cycle of inputs, check outputs mid-cycle, then advance the model at the edge.
    task automatic step(input string tag, input bit rn, input bit cen, input bit cin,
                        input bit ce, input logic [7:0] a);
        bit c1, c0;
        rst_n         = rn;
        bus.cen       = cen;
        bus.config_in = cin;
        bus.ce        = ce;
        bus.addr      = a;
        #1;
        model_comb(a, c1, c0);
        check_eq({tag, ".out"}, 32'(bus.out), 32'(model_out(c1, c0)));
        check_eq({tag, ".cfg_done"}, 32'(bus.cfg_done), 32'(m_cnt == CFGN));
        check_eq({tag, ".config_out"}, 32'(bus.config_out), 32'(m_q[0]));
        @(posedge clk);
        if (!rn) begin
            model_reset();
        end else if (cen) begin
            m_q.push_back(cin);
            void'(m_q.pop_front());
            if (m_cnt < CFGN) m_cnt++;
        end else if (ce && m_cnt == CFGN) begin
            m_r1 = c1;
            m_r0 = c0;
        end
        @(negedge clk);
    endtask

    task automatic load_frame(input string tag, input logic [34:0] f);
        for (int i = CFGN - 1; i >= 0; i--) begin
            step(tag, 1'b1, 1'b1, f[i], 1'($urandom_range(0, 1)), 8'($urandom));
        end
    endtask

    function automatic logic [34:0] mk_frame(input bit fr, input bit r1, input bit r0,
                                             input logic [15:0] l1, input logic [15:0] l0);
        return {fr, r1, r0, l1, l0};
    endfunction

    initial begin
        logic [34:0] f;
        rst_n = 1'b0;
        bus.cen = 1'b0;
        bus.ce = 1'b0;
        bus.config_in = 1'b0;
        bus.addr = '0;
        repeat (2) @(posedge clk);
        model_reset();
        @(negedge clk);

        // Reset state: outputs stay low even with ce asserted
        for (int i = 0; i < 4; i++) step("rst", 1'b1, 1'b0, 1'b0, 1'b1, 8'($urandom));
        check_eq("rst.done_direct", 32'(bus.cfg_done), 32'd0);

        // Fractured load; cfg_done must be low after 34 shifts
        f = mk_frame(1'b1, 1'b0, 1'b0, 16'h8000, 16'h6996);
        for (int i = CFGN - 1; i >= 1; i--) step("frac_ld", 1'b1, 1'b1, f[i], 1'b0, 8'h00);
        check_eq("frac.done34", 32'(bus.cfg_done), 32'd0);
        step("frac_ld", 1'b1, 1'b1, f[0], 1'b0, 8'h00);
        check_eq("frac.done35", 32'(bus.cfg_done), 32'd1);
        step("frac_f0", 1'b1, 1'b0, 1'b0, 1'b0, 8'hF0);
        step("frac_f1", 1'b1, 1'b0, 1'b0, 1'b0, 8'hF1);
        step("frac_e3", 1'b1, 1'b0, 1'b0, 1'b0, 8'hE3);

        // Unfractured cascade
        load_frame("casc_ld", mk_frame(1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h0100));
        step("casc_00", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        #1 check_eq("casc.out_direct", 32'(bus.out), 32'h3);
        load_frame("casc_ld2", mk_frame(1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h0001));
        step("casc2_00", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        #1 check_eq("casc2.out_direct", 32'(bus.out), 32'h2);

        // Registered outputs
        load_frame("reg_ld", mk_frame(1'b1, 1'b1, 1'b1, 16'h8000, 16'h8000));
        step("reg_pre", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        step("reg_ff", 1'b1, 1'b0, 1'b0, 1'b1, 8'hFF);
        step("reg_ff2", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        step("reg_hold", 1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        step("reg_clr", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);

        // Cen/ce overlap with registered q set: q holds, shift applies
        step("ovl_set", 1'b1, 1'b0, 1'b0, 1'b1, 8'hFF);
        step("ovl", 1'b1, 1'b1, 1'b1, 1'b1, 8'h00);
        step("ovl_post", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);

        // Readback: shifting zeros emits the loaded frame MSB-first
        f = mk_frame(1'b1, 1'b0, 1'b1, 16'($urandom), 16'($urandom));
        load_frame("rb_ld", f);
        for (int i = CFGN - 1; i >= 0; i--) begin
            #1 check_eq("rb.bit", 32'(bus.config_out), 32'(f[i]));
            step("rb", 1'b1, 1'b1, 1'b0, 1'b0, 8'($urandom));
        end
        check_eq("rb.done", 32'(bus.cfg_done), 32'd1);
        step("rb_zero", 1'b1, 1'b0, 1'b0, 1'b0, 8'($urandom));

        // Reset mid-load discards the partial frame
        f = mk_frame(1'b1, 1'b0, 1'b0, 16'h8000, 16'h6996);
        for (int i = CFGN - 1; i >= CFGN - 20; i--) step("mid_ld", 1'b1, 1'b1, f[i], 1'b0, 8'h00);
        step("mid_rst", 1'b0, 1'b1, 1'b1, 1'b1, 8'h00);
        check_eq("mid.done", 32'(bus.cfg_done), 32'd0);
        for (int i = CFGN - 1; i >= 1; i--) step("mid_re", 1'b1, 1'b1, f[i], 1'b0, 8'h00);
        check_eq("mid.done34", 32'(bus.cfg_done), 32'd0);
        step("mid_re", 1'b1, 1'b1, f[0], 1'b0, 8'h00);
        step("mid_f0", 1'b1, 1'b0, 1'b0, 1'b0, 8'hF0);
        step("mid_f1", 1'b1, 1'b0, 1'b0, 1'b0, 8'hF1);

        // Random traffic: mostly user cycles, occasional shifts, full reloads and resets
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 39) == 0) begin
                load_frame("rnd_ld", 35'({$urandom, $urandom}));
            end else begin
                step("rnd", ($urandom_range(0, 99) != 0), ($urandom_range(0, 7) == 0),
                     1'($urandom), 1'($urandom), 8'($urandom));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
